vec_mul_result_stage: RTL and testbench
=======================================

# vec_mul_result_stage

Registered output stage of the vector Vedic multiplier, directly downstream of the Kogge-Stone prefix adder that produces the final double-width lane products. It accepts the packed 64-bit product word with its opcode and precision, selects the low or high half of each lane product, and presents the 32-bit packed result on a valid/ready interface. A two-entry skid buffer absorbs output backpressure without creating a combinational ready path back into the adder pipeline.

## Interface
- TAG_W, 4, width of the sideband tag carried alongside each transaction
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream product word valid
- in_ready  out  1  stage can accept a word this cycle
- in_product  in  64  packed lane products from prefix adder
- in_opcode  in  2  00 MUL, 01 MULH, 10 MULHU, 11 MULSU
- in_precision  in  2  00 8-bit, 01 16-bit, 10 32-bit, 11 reserved
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  32  packed lane results
- out_tag  out  TAG_W  tag of the presented result
- out_ovf  out  4  per-lane signed-overflow flags (see Configuration)

## Operation
- Lane width W: 8 / 16 / 32 for precision 00 / 01 / 10; precision 11 is handled exactly as 10.
- Lane i product occupies in_product[i*2W +: 2W]; lane count 32/W (4, 2, 1).
- MUL: out lane i = low W bits of lane i product. MULH/MULHU/MULSU: out lane i = high W bits. Lane i result occupies out_result[i*W +: W].
- Selection is combinational on the input side; only the selected 32-bit result, tag and flags are stored.
- Storage: main output register (drives outputs) plus one skid register.
- Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
- in_ready = ~skid_valid & ~rst.
- Accept with main empty, or main draining this cycle with skid empty: data goes to main.
- Accept with main full and not draining: data goes to skid.
- Main draining while skid full: skid moves to main, skid empties; in_ready is low that cycle so no simultaneous accept.
- Ordering strictly FIFO; no word dropped or duplicated.
- Held out_* stable while out_valid & ~out_ready.

## Timing
- Latency: accepted word visible on out_* the next cycle when main is empty or draining.
- Throughput: one word per cycle with out_ready held high.
- Reset (rst high at clock edge): out_valid=0, skid_valid=0, out_result=0, out_tag=0, out_ovf=0; in_ready=0 while rst is high and 1 the cycle after.
- Reset mid-transfer discards main and skid contents; no output for words accepted before reset.
- in_ready falls the cycle after the skid fills; rises the cycle after the skid drains.
- out_valid may not fall without a completed output transfer (except reset).

## Configuration
- VEC_RES_OVF_FLAG_EN defined: for opcode MUL, out_ovf[i]=1 when lane i high half is not the sign-extension of lane i low-half MSB; lanes beyond the lane count and all non-MUL opcodes give 0. Flags registered with the result and follow the same skid path.
- Undefined: out_ovf tied to 4'b0000; no flag storage synthesized.

## Test plan
- Precision 00, MUL, product 64'h0102_0304_0506_0708 -> out_result 32'h02040608 one cycle after accept; same with MULH -> 32'h01030507.
- Precision 10, MULHU, product 64'hDEADBEEF_12345678, tag 4'hA -> out_result 32'hDEADBEEF, out_tag 4'hA; precision 11 same stimulus -> identical result.
- Overflow (macro on): precision 01, MUL, lane0 32'h0000_8000, lane1 32'hFFFF_8000 -> out_result 32'h8000_8000, out_ovf 4'b0001; macro off -> out_ovf 0.
- Backpressure: stream tags 1..6 back-to-back, out_ready low for 3 cycles -> in_ready low after skid fills, all six emerge in order, none lost or repeated, out_* stable while stalled.
- Reset mid-stream with main and skid full -> next cycle out_valid=0, out_result=0, in_ready=1; no stale word emitted afterward.
- Random opcode/precision/ready traffic against a reference model -> zero mismatches over 10k transactions.

Source files
------------

// File: rtl/vec_mul_result_stage_if.sv
// Handshake bundle for the vector multiplier result stage.
//   Input side : in_valid/in_ready with the packed 64-bit lane products,
//                opcode, precision and a sideband tag.
//   Output side: out_valid/out_ready with the packed 32-bit lane results,
//                the tag and per-lane signed-overflow flags.
// The slave modport is the result stage's view; master is the view of
// whatever sits around it (adder pipeline upstream, consumer downstream).
interface vec_mul_result_stage_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_product;
  logic [1:0]       in_opcode;
  logic [1:0]       in_precision;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_ovf;

  modport master (
    output in_valid, in_product, in_opcode, in_precision, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_opcode, in_precision, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_ovf
  );
endinterface

// File: rtl/vec_mul_result_stage.sv
// Registered output stage of the vector Vedic multiplier.
// Takes the double-width lane products from the prefix adder, keeps the low
// half (MUL) or high half (MULH/MULHU/MULSU) of each lane, and presents the
// packed 32-bit result on a valid/ready interface. A main register drives
// the outputs and a skid register absorbs one extra word, so in_ready only
// depends on local state and never on out_ready.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - vec_mul_result_stage_if.slave (in_* product side, out_* result side)
//
// Optional feature: define VEC_RES_OVF_FLAG_EN to compute per-lane signed
// overflow flags for MUL; otherwise out_ovf is constant zero and no flag
// storage exists.
module vec_mul_result_stage #(
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  vec_mul_result_stage_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_FULL
  } occ_t;

  occ_t             state, state_nxt;
  logic             accept, drain;
  logic             ld_main_in, ld_main_skid, ld_skid;
  logic             vld_p1, skid_vld_p1;
  logic [31:0]      sel_result_p0;
  logic [31:0]      main_result_p1, skid_result_p1;
  logic [TAG_W-1:0] main_tag_p1, skid_tag_p1;

  // Low half for MUL, high half for every other opcode. Precision 11 falls
  // into the 32-bit case.
  function automatic logic [31:0] lane_select(input logic [63:0] prod,
                                              input logic [1:0]  op,
                                              input logic [1:0]  prec);
    logic        hi;
    logic [31:0] res;
    hi  = (op != 2'b00);
    res = '0;
    case (prec)
      2'b00: begin
        for (int i = 0; i < 4; i++)
          res[i*8 +: 8] = hi ? prod[i*16+8 +: 8] : prod[i*16 +: 8];
      end
      2'b01: begin
        for (int i = 0; i < 2; i++)
          res[i*16 +: 16] = hi ? prod[i*32+16 +: 16] : prod[i*32 +: 16];
      end
      default: res = hi ? prod[63:32] : prod[31:0];
    endcase
    return res;
  endfunction

  // ---- p0: combinational lane selection on the input side ----
  assign sel_result_p0 = lane_select(bus.in_product, bus.in_opcode, bus.in_precision);

  assign vld_p1      = (state != ST_EMPTY);
  assign skid_vld_p1 = (state == ST_FULL);
  assign bus.in_ready = ~skid_vld_p1 & ~rst;
  assign accept      = bus.in_valid & bus.in_ready;
  assign drain       = vld_p1 & bus.out_ready;

  // Occupancy: EMPTY -> MAIN -> FULL (main + skid). In FULL in_ready is low,
  // so an accept never coincides with the skid-to-main move.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_nxt  = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (accept && drain) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid   = 1'b1;
          state_nxt = ST_FULL;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          ld_main_skid = 1'b1;
          state_nxt    = ST_MAIN;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // ---- p1: main (output) and skid registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      main_result_p1 <= '0;
      main_tag_p1    <= '0;
      skid_result_p1 <= '0;
      skid_tag_p1    <= '0;
    end else begin
      if (ld_main_in) begin
        main_result_p1 <= sel_result_p0;
        main_tag_p1    <= bus.in_tag;
      end else if (ld_main_skid) begin
        main_result_p1 <= skid_result_p1;
        main_tag_p1    <= skid_tag_p1;
      end
      if (ld_skid) begin
        skid_result_p1 <= sel_result_p0;
        skid_tag_p1    <= bus.in_tag;
      end
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.out_result = main_result_p1;
  assign bus.out_tag    = main_tag_p1;

`ifdef VEC_RES_OVF_FLAG_EN
  logic [3:0] ovf_p0, main_ovf_p1, skid_ovf_p1;

  // A lane product fits in W signed bits exactly when shifting it right
  // arithmetically by W-1 leaves all zeros or all ones.
  function automatic logic [3:0] lane_ovf(input logic [63:0] prod,
                                          input logic [1:0]  op,
                                          input logic [1:0]  prec);
    logic signed [15:0] p8;
    logic signed [31:0] p16;
    logic signed [63:0] p32;
    logic [3:0]         f;
    f = '0;
    if (op == 2'b00) begin
      case (prec)
        2'b00: begin
          for (int i = 0; i < 4; i++) begin
            p8   = prod[i*16 +: 16];
            f[i] = ((p8 >>> 7) != '0) && ((p8 >>> 7) != '1);
          end
        end
        2'b01: begin
          for (int i = 0; i < 2; i++) begin
            p16  = prod[i*32 +: 32];
            f[i] = ((p16 >>> 15) != '0) && ((p16 >>> 15) != '1);
          end
        end
        default: begin
          p32  = prod;
          f[0] = ((p32 >>> 31) != '0) && ((p32 >>> 31) != '1);
        end
      endcase
    end
    return f;
  endfunction

  assign ovf_p0 = lane_ovf(bus.in_product, bus.in_opcode, bus.in_precision);

  always_ff @(posedge clk) begin
    if (rst) begin
      main_ovf_p1 <= '0;
      skid_ovf_p1 <= '0;
    end else begin
      if (ld_main_in)        main_ovf_p1 <= ovf_p0;
      else if (ld_main_skid) main_ovf_p1 <= skid_ovf_p1;
      if (ld_skid)           skid_ovf_p1 <= ovf_p0;
    end
  end

  assign bus.out_ovf = main_ovf_p1;
`else
  assign bus.out_ovf = 4'b0000;
`endif

endmodule

// File: tb/tb_vec_mul_result_stage.sv
// Self-checking bench for vec_mul_result_stage: directed vectors with
// constant expectations plus a scoreboard fed by an independent bit-level
// model of lane selection and overflow.
module tb_vec_mul_result_stage;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_mul_result_stage_if #(.TAG_W(TAG_W)) bus();
  vec_mul_result_stage #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [63:0] p, input logic [1:0] op,
                                               input logic [1:0] prec);
    int w, off;
    logic [31:0] r;
    r   = '0;
    w   = (prec == 2'b00) ? 8 : (prec == 2'b01) ? 16 : 32;
    off = (op == 2'b00) ? 0 : w;
    for (int i = 0; i < 32 / w; i++)
      for (int b = 0; b < w; b++)
        r[i*w+b] = p[i*2*w+off+b];
    return r;
  endfunction

  function automatic logic [3:0] model_ovf(input logic [63:0] p, input logic [1:0] op,
                                           input logic [1:0] prec);
    logic [3:0] f;
    f = '0;
`ifdef VEC_RES_OVF_FLAG_EN
    if (op == 2'b00) begin
      int w;
      w = (prec == 2'b00) ? 8 : (prec == 2'b01) ? 16 : 32;
      for (int i = 0; i < 32 / w; i++)
        for (int b = 0; b < w; b++)
          if (p[i*2*w+w+b] != p[i*2*w+w-1]) f[i] = 1'b1;
    end
`endif
    return f;
  endfunction

  logic [39:0] exp_q[$];
  logic [3:0]  out_log[$];
  logic        stall_prev = 1'b0;
  logic [39:0] held;

  // Monitor: samples on the falling edge, between driver updates.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", 64'({bus.out_valid, bus.out_result, bus.out_tag, bus.out_ovf}),
              64'({1'b1, held}));
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0)
          check("sb_data", 64'({bus.out_result, bus.out_tag, bus.out_ovf}),
                64'(exp_q.pop_front()));
        out_log.push_back(bus.out_tag);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({model_result(bus.in_product, bus.in_opcode, bus.in_precision),
                         bus.in_tag,
                         model_ovf(bus.in_product, bus.in_opcode, bus.in_precision)});
        n_acc++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = {bus.out_result, bus.out_tag, bus.out_ovf};
    end
  end

  task automatic send(input logic [63:0] p, input logic [1:0] op, input logic [1:0] prec,
                      input logic [3:0] tag);
    int g;
    bus.in_product   = p;
    bus.in_opcode    = op;
    bus.in_precision = prec;
    bus.in_tag       = tag;
    bus.in_valid     = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) check("send_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int g;
    g = 0;
    while (bus.out_valid && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    check(tag, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ovf;
    int cyc;
    logic fire;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_product = '0;
    bus.in_opcode = '0;
    bus.in_precision = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Directed lane selection
    send(64'h0102_0304_0506_0708, 2'b00, 2'b00, 4'h1);
`ifdef VEC_RES_OVF_FLAG_EN
    exp_ovf = 4'b1111;
`else
    exp_ovf = 4'b0000;
`endif
    check("mul8_valid", 64'(bus.out_valid), 64'd1);
    check("mul8_result", 64'(bus.out_result), 64'h0204_0608);
    check("mul8_ovf", 64'(bus.out_ovf), 64'(exp_ovf));
    send(64'h0102_0304_0506_0708, 2'b01, 2'b00, 4'h2);
    check("mulh8_result", 64'(bus.out_result), 64'h0103_0507);
    check("mulh8_ovf", 64'(bus.out_ovf), 64'd0);
    send(64'hDEADBEEF_12345678, 2'b10, 2'b10, 4'hA);
    check("mulhu32_result", 64'(bus.out_result), 64'hDEAD_BEEF);
    check("mulhu32_tag", 64'(bus.out_tag), 64'hA);
    send(64'hDEADBEEF_12345678, 2'b10, 2'b11, 4'hA);
    check("prec11_result", 64'(bus.out_result), 64'hDEAD_BEEF);
    send(64'hDEADBEEF_12345678, 2'b00, 2'b10, 4'h5);
    check("mul32_result", 64'(bus.out_result), 64'h1234_5678);
    send(64'hFFFF8000_00008000, 2'b00, 2'b01, 4'h3);
`ifdef VEC_RES_OVF_FLAG_EN
    exp_ovf = 4'b0001;
`else
    exp_ovf = 4'b0000;
`endif
    check("ovf16_result", 64'(bus.out_result), 64'h8000_8000);
    check("ovf16_ovf", 64'(bus.out_ovf), 64'(exp_ovf));
    @(posedge clk); #1;
    check("drain_empty", 64'(bus.out_valid), 64'd0);

    // Backpressure: six back-to-back words, output stalled for 3 cycles
    out_log.delete();
    bus.out_ready = 1'b0;
    send({16{4'h1}}, 2'b00, 2'b00, 4'h1);
    send({16{4'h2}}, 2'b01, 2'b01, 4'h2);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_out_tag", 64'(bus.out_tag), 64'h1);
    @(posedge clk); #1;
    check("bp_out_tag_held", 64'(bus.out_tag), 64'h1);
    bus.out_ready = 1'b1;
    for (int k = 3; k <= 6; k++) send({16{4'(k)}}, 2'(k), 2'(k), 4'(k));
    wait_empty("bp_drain");
    check("bp_count", 64'(out_log.size()), 64'd6);
    for (int k = 0; k < 6 && k < out_log.size(); k++)
      check("bp_order", 64'(out_log[k]), 64'(k + 1));

    // Reset with main and skid full
    bus.out_ready = 1'b0;
    send(64'h1111_2222_3333_4444, 2'b00, 2'b00, 4'h7);
    send(64'h5555_6666_7777_8888, 2'b00, 2'b00, 4'h8);
    check("rstmid_full", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstmid_out_result", 64'(bus.out_result), 64'd0);
    check("rstmid_in_ready_low", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
    out_log.delete();
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_stale", 64'(out_log.size()), 64'd0);
    check("rstmid_idle", 64'(bus.out_valid), 64'd0);

    // Random traffic against the scoreboard
    n_acc = 0;
    cyc = 0;
    fire = 1'b0;
    while (n_acc < 10000 && cyc < 60000) begin
      if (!bus.in_valid || fire) begin
        logic [63:0] p;
        p = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: p = {4{{8{p[7]}}, p[7:0]}};
          1: p = {2{{16{p[15]}}, p[15:0]}};
          2: p = {{32{p[31]}}, p[31:0]};
          default: ;
        endcase
        bus.in_valid     = ($urandom_range(0, 3) != 0);
        bus.in_product   = p;
        bus.in_opcode    = 2'($urandom_range(0, 3));
        bus.in_precision = 2'($urandom_range(0, 3));
        bus.in_tag       = 4'($urandom_range(0, 15));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_empty("rand_drain");
    check("rand_count", 64'(n_acc >= 10000), 64'd1);
    check("rand_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
